// File: rtl/tail_light_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tail_light_pkg
//  Purpose  : Shared definitions for the tail-light scheduler: FSM state
//             encodings and the 6-bit lamp patterns (1 = lit, [5:3] left with
//             bit5 outermost, [2:0] right with bit0 outermost).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package tail_light_pkg;

   localparam int c_ST_W = 4;
   typedef logic [c_ST_W-1:0] state_t;

   localparam state_t c_ST_IDLE    = 4'd0;
   localparam state_t c_ST_L1      = 4'd1;
   localparam state_t c_ST_L2      = 4'd2;
   localparam state_t c_ST_L3      = 4'd3;
   localparam state_t c_ST_R1      = 4'd4;
   localparam state_t c_ST_R2      = 4'd5;
   localparam state_t c_ST_R3      = 4'd6;
   localparam state_t c_ST_HAZ_ON  = 4'd7;
   localparam state_t c_ST_HAZ_OFF = 4'd8;

   localparam logic [5:0] c_LAMP_DARK = 6'b000_000;
   localparam logic [5:0] c_LAMP_L1   = 6'b001_000;
   localparam logic [5:0] c_LAMP_L2   = 6'b011_000;
   localparam logic [5:0] c_LAMP_L3   = 6'b111_000;
   localparam logic [5:0] c_LAMP_R1   = 6'b000_100;
   localparam logic [5:0] c_LAMP_R2   = 6'b000_110;
   localparam logic [5:0] c_LAMP_R3   = 6'b000_111;
   localparam logic [5:0] c_LAMP_ALL  = 6'b111_111;

   // Brake lights the half of the bank not used by the turn sequence.
   localparam logic [5:0] c_BRAKE_L   = 6'b000_111;
   localparam logic [5:0] c_BRAKE_R   = 6'b111_000;

endpackage : tail_light_pkg
`default_nettype wire

// File: rtl/tail_light_sched_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : step_prescaler
//  Purpose  : Free-running DIV_W-bit counter producing a one-clk step tick
//             every 2**DIV_W clocks (tick while the counter is all-ones).
//  Ports    : clk  - board clock
//             rst  - synchronous, active-low reset (counter to zero)
//             tick - one-cycle step strobe
//  Revision : 1.0  initial release
// ============================================================================
module step_prescaler #(
   parameter int DIV_W = 23
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [DIV_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // First tick lands 2**DIV_W clocks after reset release.
   assign tick = &r_cnt;

endmodule : step_prescaler
`default_nettype wire

// File: rtl/tail_light_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tail_light_sched
//  Purpose  : Tail-light scheduler. Arbitrates left/right turn, hazard and
//             brake requests, runs the outward-chase turn pattern at the
//             prescaled step rate and drives active-low LEDs.
//  Ports    : clk     - board clock
//             rst     - synchronous, active-low reset
//             l_req   - left turn request (level)
//             r_req   - right turn request (level)
//             haz_req - hazard request (level)
//             brake   - brake pedal (level)
//             led     - 6-bit active-low lamp drive, [5:3] left, [2:0] right
//             busy    - high while the sequencer is not idle
//  Revision : 1.0  initial release
// ============================================================================
module tail_light_sched
   import tail_light_pkg::*;
#(
   parameter int DIV_W = 23
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       l_req,
   input  logic       r_req,
   input  logic       haz_req,
   input  logic       brake,
   output logic [5:0] led,
   output logic       busy
);

   logic       w_tick;
   logic       w_hz;
   logic       w_l_rev;
   logic       w_r_rev;
   state_t     r_state;
   state_t     w_next_state;
   logic [5:0] w_lamp;
   logic [5:0] r_led;
   logic       r_busy;

   step_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // Both turn requests together behave as a hazard request.
   assign w_hz    = haz_req | (l_req & r_req);
   // Opposite-side-only request aborts a running turn sequence.
   assign w_l_rev = r_req & ~l_req;
   assign w_r_rev = l_req & ~r_req;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_IDLE: if (w_tick) begin
            if (w_hz)       w_next_state = c_ST_HAZ_ON;
            else if (l_req) w_next_state = c_ST_L1;
            else if (r_req) w_next_state = c_ST_R1;
         end
         c_ST_L1: if (w_tick) begin
            if (w_hz)         w_next_state = c_ST_HAZ_ON;
            else if (w_l_rev) w_next_state = c_ST_IDLE;
            else              w_next_state = c_ST_L2;
         end
         c_ST_L2: if (w_tick) begin
            if (w_hz)         w_next_state = c_ST_HAZ_ON;
            else if (w_l_rev) w_next_state = c_ST_IDLE;
            else              w_next_state = c_ST_L3;
         end
         c_ST_L3: if (w_tick) w_next_state = c_ST_IDLE;
         c_ST_R1: if (w_tick) begin
            if (w_hz)         w_next_state = c_ST_HAZ_ON;
            else if (w_r_rev) w_next_state = c_ST_IDLE;
            else              w_next_state = c_ST_R2;
         end
         c_ST_R2: if (w_tick) begin
            if (w_hz)         w_next_state = c_ST_HAZ_ON;
            else if (w_r_rev) w_next_state = c_ST_IDLE;
            else              w_next_state = c_ST_R3;
         end
         c_ST_R3: if (w_tick) w_next_state = c_ST_IDLE;
         c_ST_HAZ_ON: if (w_tick) w_next_state = c_ST_HAZ_OFF;
         c_ST_HAZ_OFF: if (w_tick) begin
            if (w_hz) w_next_state = c_ST_HAZ_ON;
            else      w_next_state = c_ST_IDLE;
         end
         // Unused encodings fall back to IDLE immediately, not on a tick.
         default: w_next_state = c_ST_IDLE;
      endcase
   end

   // ---------------- output decode (pattern + brake overlay) ----------------
   always_comb begin
      w_lamp = c_LAMP_DARK;
      case (w_next_state)
         c_ST_IDLE:    w_lamp = brake ? c_LAMP_ALL : c_LAMP_DARK;
         c_ST_L1:      w_lamp = c_LAMP_L1 | (brake ? c_BRAKE_L : c_LAMP_DARK);
         c_ST_L2:      w_lamp = c_LAMP_L2 | (brake ? c_BRAKE_L : c_LAMP_DARK);
         c_ST_L3:      w_lamp = c_LAMP_L3 | (brake ? c_BRAKE_L : c_LAMP_DARK);
         c_ST_R1:      w_lamp = c_LAMP_R1 | (brake ? c_BRAKE_R : c_LAMP_DARK);
         c_ST_R2:      w_lamp = c_LAMP_R2 | (brake ? c_BRAKE_R : c_LAMP_DARK);
         c_ST_R3:      w_lamp = c_LAMP_R3 | (brake ? c_BRAKE_R : c_LAMP_DARK);
         c_ST_HAZ_ON:  w_lamp = c_LAMP_ALL;
         c_ST_HAZ_OFF: w_lamp = c_LAMP_DARK;
         default:      w_lamp = c_LAMP_DARK;
      endcase
   end

   // LED drive is registered from the next state so a state change shows
   // one clk after its tick edge and brake changes show one clk after sampling.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_led  <= 6'b111_111;
         r_busy <= 1'b0;
      end else begin
         r_led  <= ~w_lamp;
         r_busy <= (w_next_state != c_ST_IDLE);
      end
   end

   assign led  = r_led;
   assign busy = r_busy;

endmodule : tail_light_sched
`default_nettype wire

// File: tb/tb_tail_light_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tail_light_sched
//  Purpose  : Self-checking bench for tail_light_sched (DIV_W = 2) comparing
//             led/busy every clock against a behavioural lamp model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tail_light_sched;

   logic       clk;
   logic       rst;
   logic       l_req;
   logic       r_req;
   logic       haz_req;
   logic       brake;
   logic [5:0] led;
   logic       busy;

   int total;
   int bad;

   // Behavioural model: which side is active and how far along it is.
   // side: 0 none, 1 left chase, 2 right chase, 3 hazard (step 1 = on, 0 = off)
   int         m_cnt;
   int         m_side;
   int         m_step;
   logic [5:0] exp_led;
   logic       exp_busy;

   tail_light_sched #(
      .DIV_W (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .l_req   (l_req),
      .r_req   (r_req),
      .haz_req (haz_req),
      .brake   (brake),
      .led     (led),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s t=%0t got=%b want=%b", tag, $time, obs, expv);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic       tick;
      logic       hz;
      logic       own;
      logic       oth;
      logic [5:0] lit;
      if (!rst) begin
         m_cnt  = 0;
         m_side = 0;
         m_step = 0;
      end else begin
         tick  = (m_cnt == 3);
         m_cnt = (m_cnt + 1) % 4;
         hz    = haz_req | (l_req & r_req);
         if (tick) begin
            if (m_side == 0) begin
               if (hz)         begin m_side = 3; m_step = 1; end
               else if (l_req) begin m_side = 1; m_step = 1; end
               else if (r_req) begin m_side = 2; m_step = 1; end
            end else if (m_side == 1 || m_side == 2) begin
               own = (m_side == 1) ? l_req : r_req;
               oth = (m_side == 1) ? r_req : l_req;
               if (m_step == 3)      m_side = 0;
               else if (hz)          begin m_side = 3; m_step = 1; end
               else if (oth && !own) m_side = 0;
               else                  m_step = m_step + 1;
            end else begin
               if (m_step == 1) m_step = 0;
               else if (hz)     m_step = 1;
               else             m_side = 0;
            end
         end
      end
      // Lamp pattern computed arithmetically from side/step.
      lit = 6'd0;
      if (m_side == 1) begin
         lit = 6'(((1 << m_step) - 1) << 3);
         if (brake) lit = lit | 6'b000_111;
      end else if (m_side == 2) begin
         lit = 6'((7 << (3 - m_step)) & 7);
         if (brake) lit = lit | 6'b111_000;
      end else if (m_side == 3) begin
         lit = (m_step == 1) ? 6'b111_111 : 6'b000_000;
      end else begin
         lit = brake ? 6'b111_111 : 6'b000_000;
      end
      exp_led  = (!rst) ? 6'b111_111 : ~lit;
      exp_busy = (!rst) ? 1'b0 : (m_side != 0);
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clk);
      #1;
      chk({tag, ".led"}, {2'b00, led}, {2'b00, exp_led});
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, exp_busy});
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic set_in(input logic l, input logic r, input logic h, input logic b);
      l_req   = l;
      r_req   = r;
      haz_req = h;
      brake   = b;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      run("reset", n);
      rst = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_cnt = 0; m_side = 0; m_step = 0;
      rst   = 1'b0;
      set_in(1'b1, 1'b0, 1'b0, 1'b0);

      // Reset held with a turn request pending, then a held left request.
      do_reset(3);
      run("left_held", 20);

      // Single-tick left pulse: sequence must still complete.
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      do_reset(1);
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      run("left_pulse", 4);
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      run("left_pulse", 16);

      // Both turns with brake behaves as hazard, brake ignored.
      set_in(1'b1, 1'b1, 1'b0, 1'b1);
      run("hz_lr", 12);
      set_in(1'b0, 1'b0, 1'b1, 1'b1);
      run("hz_haz", 8);

      // Brake with right request, then brake dropped in R2.
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      do_reset(1);
      set_in(1'b0, 1'b1, 1'b0, 1'b1);
      run("brake_r", 9);
      brake = 1'b0;
      run("brake_drop", 2);
      brake = 1'b1;
      run("brake_r", 8);

      // Reversal out of L1.
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      do_reset(1);
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      run("rev", 4);
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      run("rev", 4);

      // Reset while in L2.
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      do_reset(1);
      run("mid_rst", 9);
      do_reset(1);
      run("after_rst", 8);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            l_req   = ($urandom_range(0, 2) == 0);
            r_req   = ($urandom_range(0, 2) == 0);
            haz_req = ($urandom_range(0, 7) == 0);
         end
         if ($urandom_range(0, 7) == 0) brake = ~brake;
         rst = ($urandom_range(0, 99) != 0);
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_tail_light_sched
`default_nettype wire
